// File: rtl/median_pkg.sv
// Shared definitions for the median filter front end: default frame geometry
// and the frame arbiter state encoding.
package median_pkg;

    localparam int IMG_WIDTH_DEF  = 240;
    localparam int IMG_HEIGHT_DEF = 200;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arbState_e;

endpackage

// File: rtl/median_frame_counter.sv
// Column/row position tracker for one video frame; advances once per accepted
// beat and flags start of frame, end of line and end of frame.
module median_frame_counter
    import median_pkg::*;
#(
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
    parameter int CW         = 8,
    parameter int RW         = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic advance,
    output logic sof,
    output logic eol,
    output logic eof
);

    logic [CW-1:0] col;
    logic [RW-1:0] row;

    assign sof = (col == '0) && (row == '0);
    assign eol = (col == CW'(IMG_WIDTH - 1));
    assign eof = eol && (row == RW'(IMG_HEIGHT - 1));

    // Wrapping at the last beat of the frame brings both counters back to 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col <= '0;
            row <= '0;
        end else if (advance) begin
            if (eol) begin
                col <= '0;
                row <= eof ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/median_frame_arbiter.sv
// Frame-granular arbiter sharing one median filter between two AXI-Stream
// sources; regenerates tUser/tLast from its own counters and flags framing errors.
module median_frame_arbiter
    import median_pkg::*;
#(
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
    parameter int CW         = 8,
    parameter int RW         = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] AXIS_In0_tData,
    input  logic       AXIS_In0_tValid,
    output logic       AXIS_In0_tReady,
    input  logic       AXIS_In0_tUser,
    input  logic       AXIS_In0_tLast,
    input  logic [7:0] AXIS_In1_tData,
    input  logic       AXIS_In1_tValid,
    output logic       AXIS_In1_tReady,
    input  logic       AXIS_In1_tUser,
    input  logic       AXIS_In1_tLast,
    output logic [7:0] AXIS_Out_tData,
    output logic       AXIS_Out_tValid,
    input  logic       AXIS_Out_tReady,
    output logic       AXIS_Out_tUser,
    output logic       AXIS_Out_tLast,
    output logic [1:0] grant,
    output logic       frame_done,
    output logic [1:0] err_sync,
    output logic [1:0] err_frame,
    input  logic       err_clr
);

    arbState_e  state;
    arbState_e  nextState;
    logic       lastOwner;
    logic [1:0] flushBeat;
    logic [1:0] reqBeat;
    logic       outHandshake;
    logic       frameEnd;
    logic       sof;
    logic       eol;
    logic       eof;
    logic [1:0] syncErr;
    logic [1:0] frameErr;

    assign flushBeat    = {AXIS_In1_tValid & ~AXIS_In1_tUser, AXIS_In0_tValid & ~AXIS_In0_tUser};
    assign reqBeat      = {AXIS_In1_tValid &  AXIS_In1_tUser, AXIS_In0_tValid &  AXIS_In0_tUser};
    assign outHandshake = AXIS_Out_tValid & AXIS_Out_tReady;
    assign frameEnd     = outHandshake & eof;

    median_frame_counter #(
        .IMG_WIDTH (IMG_WIDTH),
        .IMG_HEIGHT(IMG_HEIGHT),
        .CW        (CW),
        .RW        (RW)
    ) frameCounter (
        .clk    (clk),
        .reset  (reset),
        .advance(outHandshake),
        .sof    (sof),
        .eol    (eol),
        .eof    (eof)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // On a tie the source that did not own the previous frame wins.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (reqBeat == 2'b11) begin
                    nextState = lastOwner ? GNT0 : GNT1;
                end else if (reqBeat[0]) begin
                    nextState = GNT0;
                end else if (reqBeat[1]) begin
                    nextState = GNT1;
                end
            end
            GNT0, GNT1: begin
                if (frameEnd) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        AXIS_Out_tData  = '0;
        AXIS_Out_tValid = 1'b0;
        AXIS_Out_tUser  = 1'b0;
        AXIS_Out_tLast  = 1'b0;
        AXIS_In0_tReady = 1'b0;
        AXIS_In1_tReady = 1'b0;
        grant           = 2'b00;
        syncErr         = 2'b00;
        frameErr        = 2'b00;
        case (state)
            IDLE: begin
                AXIS_In0_tReady = flushBeat[0];
                AXIS_In1_tReady = flushBeat[1];
                syncErr         = flushBeat;
            end
            GNT0: begin
                grant           = 2'b01;
                AXIS_Out_tData  = AXIS_In0_tData;
                AXIS_Out_tValid = AXIS_In0_tValid;
                AXIS_Out_tUser  = sof;
                AXIS_Out_tLast  = eol;
                AXIS_In0_tReady = AXIS_Out_tReady;
                frameErr[0]     = AXIS_In0_tValid & AXIS_Out_tReady &
                                  ((AXIS_In0_tLast != eol) | (AXIS_In0_tUser & ~sof));
            end
            GNT1: begin
                grant           = 2'b10;
                AXIS_Out_tData  = AXIS_In1_tData;
                AXIS_Out_tValid = AXIS_In1_tValid;
                AXIS_Out_tUser  = sof;
                AXIS_Out_tLast  = eol;
                AXIS_In1_tReady = AXIS_Out_tReady;
                frameErr[1]     = AXIS_In1_tValid & AXIS_Out_tReady &
                                  ((AXIS_In1_tLast != eol) | (AXIS_In1_tUser & ~sof));
            end
            default: ;
        endcase
    end

    // New errors take priority over a clear arriving in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lastOwner  <= 1'b1;
            frame_done <= 1'b0;
            err_sync   <= 2'b00;
            err_frame  <= 2'b00;
        end else begin
            frame_done <= frameEnd;
            if (frameEnd) begin
                lastOwner <= (state == GNT1);
            end
            err_sync  <= (err_sync  & ~{2{err_clr}}) | syncErr;
            err_frame <= (err_frame & ~{2{err_clr}}) | frameErr;
        end
    end

endmodule

// File: doc/median_frame_arbiter.md
Name: median_frame_arbiter

Overview:
- Shares one median filter instance between two 8-bit AXI-Stream video sources, one whole frame at a time.
- Sits directly upstream of the median's AXIS_In port. Arbitrates only on start-of-frame (tUser) and releases the grant after counting a full frame.
- Regenerates well-formed tUser/tLast toward the filter and flags framing errors from the sources.
- Outputs grant and status for software and debug.

Parameters:
- IMG_WIDTH, 240, pixels per line.
- IMG_HEIGHT, 200, lines per frame (default frame = 48000 samples).
- CW, 8, column counter width; must satisfy 2^CW >= IMG_WIDTH.
- RW, 8, row counter width; must satisfy 2^RW >= IMG_HEIGHT.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (clk is the only clock; reset asserts asynchronously, active when 0)
- AXIS_In0_tData  in  8  source 0 pixel
- AXIS_In0_tValid  in  1  source 0 valid
- AXIS_In0_tReady  out  1  source 0 ready
- AXIS_In0_tUser  in  1  source 0 start of frame
- AXIS_In0_tLast  in  1  source 0 end of line
- AXIS_In1_tData / tValid / tReady / tUser / tLast  same widths and directions as source 0, for source 1
- AXIS_Out_tData  out  8  pixel to median
- AXIS_Out_tValid  out  1  valid to median
- AXIS_Out_tReady  in  1  median ready
- AXIS_Out_tUser  out  1  regenerated start of frame
- AXIS_Out_tLast  out  1  regenerated end of line
- grant  out  2  one-hot current owner; 00 when idle
- frame_done  out  1  one-cycle pulse after the last beat of a frame
- err_sync  out  2  sticky per source: non-SOF beat flushed while not granted
- err_frame  out  2  sticky per source: early or missing tLast, or tUser mid-frame
- err_clr  in  1  synchronous clear of err_sync and err_frame

Behaviour:
- Reset (reset=0): state IDLE, grant=00, last_owner=1 (so source 0 wins the first tie), col=0, row=0. All outputs 0: tReady, AXIS_Out_tValid, tUser, tLast, frame_done, errs.
- States: IDLE, GNT0, GNT1.
- IDLE, per source:
  - head beat with tValid=1 and tUser=0: flushed with tReady=1, and that source's err_sync bit is set.
  - head beat with tValid=1 and tUser=1: request. tReady stays 0 until granted.
  - AXIS_Out_tValid=0 while idle.
- Arbitration (IDLE only):
  - One requester: grant it.
  - Both requesting in the same cycle: round-robin against last_owner.
  - The transition to GNTx is registered. No beat passes in the decision cycle.
- GNTx, combinational pass-through with zero latency:
  - AXIS_Out_tData = Inx_tData; AXIS_Out_tValid = Inx_tValid; Inx_tReady = AXIS_Out_tReady.
  - The other source's tReady = 0; it is held, not flushed.
- Counters advance only on Out handshake (tValid & tReady).
  - col wraps at IMG_WIDTH-1 and increments row on wrap.
  - Out_tUser = (col==0 && row==0); Out_tLast = (col==IMG_WIDTH-1).
  - Both are generated from the counters. The source's tUser/tLast are never forwarded.
- Framing checks, on each handshake in GNTx:
  - Inx_tLast != (col==IMG_WIDTH-1) sets err_frame[x].
  - Inx_tUser=1 with (col,row) != (0,0) sets err_frame[x].
  - The frame continues on counter timing regardless.
- End of frame: handshake at col=IMG_WIDTH-1, row=IMG_HEIGHT-1.
  - Next cycle: state IDLE, counters 0, last_owner=x.
  - frame_done pulses for exactly one cycle.
  - The beat after the final beat is never passed in the same cycle.
- Back-pressure: AXIS_Out_tReady=0 stalls the counters. Data and valid stay mirrored from the source; there is no internal storage.
- Simultaneous events:
  - err_clr in the same cycle as a new error: the error wins (bit set).
  - New request in the frame_done cycle: considered from the IDLE cycle onward.
- Reset mid-frame: immediate return to reset values; the partial frame is abandoned and the median is not notified.

Decomposition:
- Shared package median_pkg: IMG_WIDTH/IMG_HEIGHT defaults, state encoding localparams (IDLE=2'd0, GNT0=2'd1, GNT1=2'd2).
- Sub-module median_frame_counter: col/row counters with advance, wrap, sof, eol and eof outputs. It is reused later by the median output checker.
- Arbitration FSM and mux stay in the top.

Test Plan:
- Reset release, source 0 sends a 240x200 frame with correct SOF/EOL, Out_tReady=1 -> grant=01 one cycle after SOF seen; 48000 beats pass with data identical; Out_tLast every 240th beat; one frame_done; errs 0.
- Both sources present SOF in the same cycle -> source 0 served first, then source 1. Next tie -> source 0 again, since last_owner=1.
- Source 1 streams 5 non-SOF beats while idle -> 5 beats flushed, err_sync=10, nothing on Out. err_clr -> err_sync=00.
- Source 0 asserts tLast at col 100 of line 3 -> err_frame[0]=1. Out_tLast still only at col 239. Frame still ends after beat 48000.
- Out_tReady toggles 1-0 every cycle during a frame -> counters advance only on handshakes. frame_done after exactly 48000 handshakes.
- reset driven low mid-frame at beat 1000, then released -> grant=00, all outputs 0. The next SOF from either source restarts at col=0, row=0.
